uart_mmio_ctrl: RTL and testbench

- Memory-mapped I/O controller between the CPU datapath's load/store stage and the UART receiver/transmitter.
- Buffers received bytes in a small RX FIFO and holds one outgoing TX byte.
- Provides cycle and retired-instruction counters, exposing everything as word registers.
- Read data is registered, giving 1-cycle load latency to match the synchronous memories.

---
 rtl/uart_mmio_pkg.sv | 26 ++
 rtl/mmio_sync_fifo.sv | 55 +++++
 rtl/uart_mmio_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared register map and STATUS layout for the UART MMIO controller.
package uart_mmio_pkg;

  localparam logic [7:0] ADDR_STATUS    = 8'h00;
  localparam logic [7:0] ADDR_RX_DATA   = 8'h04;
  localparam logic [7:0] ADDR_TX_DATA   = 8'h08;
  localparam logic [7:0] ADDR_CYCLE_CNT = 8'h10;
  localparam logic [7:0] ADDR_INSTR_CNT = 8'h14;
  localparam logic [7:0] ADDR_CNT_RESET = 8'h18;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_TX_OVF   = 2;

  function automatic logic [31:0] status_word(input logic tx_ready,
                                              input logic rx_valid,
                                              input logic tx_ovf);
    logic [31:0] w;
    w                = 32'h0000_0000;
    w[STAT_TX_READY] = tx_ready;
    w[STAT_RX_VALID] = rx_valid;
    w[STAT_TX_OVF]   = tx_ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with count; push ignored when full, pop ignored when empty.
module mmio_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge between the CPU load/store stage and the UART RX/TX,
// with registered 1-cycle read data plus cycle and retired-instruction counters.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        instr_retired,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_data_in_valid,
  output logic        rx_data_in_ready,
  output logic [7:0]  tx_data_out,
  output logic        tx_data_out_valid,
  input  logic        tx_data_out_ready
);

  logic [31:0]                    r_rdata;
  logic [7:0]                     r_tx_data;
  logic                           r_tx_valid;
  logic                           r_tx_ovf;
  logic [CNT_WIDTH-1:0]           r_cycle_cnt;
  logic [CNT_WIDTH-1:0]           r_instr_cnt;

  logic                           w_load;
  logic                           w_store;
  logic                           w_rx_pop;
  logic                           w_rx_full;
  logic                           w_rx_empty;
  logic [7:0]                     w_rx_head;
  logic [$clog2(RX_FIFO_DEPTH):0] w_rx_count;
  logic                           w_tx_store;
  logic                           w_tx_hs;
  logic                           w_ovf_set;
  logic                           w_ovf_clr;
  logic                           w_cnt_clr;
  logic [31:0]                    w_rd_mux;
  logic                           w_unused;

  assign w_load     = req_valid && !req_we;
  assign w_store    = req_valid && req_we;
  assign w_rx_pop   = w_load && (req_addr == ADDR_RX_DATA);
  assign w_tx_store = w_store && (req_addr == ADDR_TX_DATA);
  assign w_tx_hs    = r_tx_valid && tx_data_out_ready;
  assign w_ovf_set  = w_tx_store && r_tx_valid && !w_tx_hs;
  assign w_ovf_clr  = w_store && (req_addr == ADDR_STATUS) && req_wdata[STAT_TX_OVF];
  assign w_cnt_clr  = w_store && (req_addr == ADDR_CNT_RESET);
  assign w_unused   = ^{req_wdata, w_rx_count};

  assign rdata             = r_rdata;
  assign tx_data_out       = r_tx_data;
  assign tx_data_out_valid = r_tx_valid;
  assign rx_data_in_ready  = !w_rx_full;

  mmio_sync_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (rx_data_in_valid),
    .i_wdata (rx_data_in),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // Read mux sees pre-update state, so a popping load returns the old head.
  always_comb begin
    w_rd_mux = 32'h0000_0000;
    case (req_addr)
      ADDR_STATUS:    w_rd_mux = status_word(!r_tx_valid, !w_rx_empty, r_tx_ovf);
      ADDR_RX_DATA: begin
        if (w_rx_empty) w_rd_mux = 32'h0000_0000;
        else            w_rd_mux = {24'h00_0000, w_rx_head};
      end
      ADDR_CYCLE_CNT: w_rd_mux = 32'(r_cycle_cnt);
      ADDR_INSTR_CNT: w_rd_mux = 32'(r_instr_cnt);
      default:        w_rd_mux = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_rdata <= 32'h0000_0000;
    else if (w_load) r_rdata <= w_rd_mux;
  end

  // A store racing the handshake refills the holding register without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_tx_store && (!r_tx_valid || w_tx_hs)) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= req_wdata[7:0];
    end else if (w_tx_hs) begin
      r_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_tx_ovf <= 1'b0;
    else if (w_ovf_set) r_tx_ovf <= 1'b1;
    else if (w_ovf_clr) r_tx_ovf <= 1'b0;
  end

  // Counter clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
      if (instr_retired) r_instr_cnt <= r_instr_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_uart_mmio_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_we, instr_retired;
  logic [7:0]  req_addr, rx_data_in, tx_data_out;
  logic [31:0] req_wdata, rdata;
  logic        rx_data_in_valid, rx_data_in_ready, tx_data_out_valid, tx_data_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0]  m_q[$];
  logic        m_tx_v, m_ovf;
  logic [7:0]  m_tx_d;
  logic [31:0] m_cyc, m_ins, m_rd;

  uart_mmio_ctrl #(.RX_FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata),
    .instr_retired(instr_retired), .rx_data_in(rx_data_in),
    .rx_data_in_valid(rx_data_in_valid), .rx_data_in_ready(rx_data_in_ready),
    .tx_data_out(tx_data_out), .tx_data_out_valid(tx_data_out_valid),
    .tx_data_out_ready(tx_data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_q.delete();
    m_tx_v = 1'b0; m_tx_d = 8'h00; m_ovf = 1'b0;
    m_cyc = 32'd0; m_ins = 32'd0; m_rd = 32'd0;
  endtask

  task automatic clr_in();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
    instr_retired = 1'b0; rx_data_in = 8'h00; rx_data_in_valid = 1'b0;
    tx_data_out_ready = 1'b0;
  endtask

  // Apply current inputs to the model, then advance one clock edge.
  task automatic tick();
    logic ld, st, hs, set_ovf;
    ld = req_valid && !req_we;
    st = req_valid && req_we;
    hs = m_tx_v && tx_data_out_ready;
    set_ovf = 1'b0;
    if (ld) begin
      case (req_addr)
        8'h00:   m_rd = {29'd0, m_ovf, (m_q.size() != 0), !m_tx_v};
        8'h04:   m_rd = (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0;
        8'h10:   m_rd = m_cyc;
        8'h14:   m_rd = m_ins;
        default: m_rd = 32'd0;
      endcase
    end
    if (st && req_addr == 8'h08) begin
      if (!m_tx_v || hs) begin m_tx_v = 1'b1; m_tx_d = req_wdata[7:0]; end
      else set_ovf = 1'b1;
    end else if (hs) m_tx_v = 1'b0;
    if (set_ovf) m_ovf = 1'b1;
    else if (st && req_addr == 8'h00 && req_wdata[2]) m_ovf = 1'b0;
    begin
      logic do_push;
      do_push = rx_data_in_valid && (m_q.size() < DEPTH);
      if (ld && req_addr == 8'h04 && m_q.size() != 0) void'(m_q.pop_front());
      if (do_push) m_q.push_back(rx_data_in);
    end
    if (st && req_addr == 8'h18) begin m_cyc = 32'd0; m_ins = 32'd0; end
    else begin m_cyc = m_cyc + 32'd1; m_ins = m_ins + {31'd0, instr_retired}; end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic store(input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want %h", rdata, 32'h0); end
    n_checks++; if (tx_data_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_data_out_valid); end
    n_checks++; if (tx_data_out !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data_out); end
    n_checks++; if (rx_data_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 1", rx_data_in_ready); end
    load(8'h00);
    n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL rst_status: got %h want %h", rdata, 32'h1); end
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      instr_retired = (i % 3 == 0);
      tick();
    end
    instr_retired = 1'b0;
    load(8'h10);
    n_checks++; if (rdata !== 32'd100) begin n_fail++; $display("FAIL cycle_cnt: got %0d want 100", rdata); end
    load(8'h14);
    n_checks++; if (rdata !== 32'd34) begin n_fail++; $display("FAIL instr_cnt: got %0d want 34", rdata); end
    instr_retired = 1'b1;
    store(8'h18, $urandom);
    instr_retired = 1'b0;
    load(8'h14);
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL instr_cnt_clr: got %0d want 0", rdata); end
    load(8'h10);
    n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL cycle_cnt_clr: got %0d want 1", rdata); end
  endtask

  task automatic test_rx_fill();
    logic [7:0] want;
    do_reset();
    rx_data_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data_in = 8'(8'h11 * (i + 1));
      tick();
    end
    rx_data_in_valid = 1'b0;
    n_checks++; if (rx_data_in_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", rx_data_in_ready); end
    load(8'h00);
    n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL rx_full_status: got %h want %h", rdata, 32'h3); end
    rx_data_in_valid = 1'b1; rx_data_in = 8'h55;
    tick();
    rx_data_in_valid = 1'b0;
    n_checks++; if (rx_data_in_ready !== 1'b0) begin n_fail++; $display("FAIL rx_held_off: got %b want 0", rx_data_in_ready); end
    for (int i = 0; i < 4; i++) begin
      want = 8'(8'h11 * (i + 1));
      load(8'h04);
      n_checks++; if (rdata !== {24'd0, want}) begin n_fail++; $display("FAIL rx_drain%0d: got %h want %h", i, rdata, want); end
    end
    n_checks++; if (rx_data_in_ready !== 1'b1) begin n_fail++; $display("FAIL rx_empty_ready: got %b want 1", rx_data_in_ready); end
    rx_data_in_valid = 1'b1; rx_data_in = 8'h55;
    tick();
    rx_data_in_valid = 1'b0;
    load(8'h04);
    n_checks++; if (rdata !== 32'h55) begin n_fail++; $display("FAIL rx_fifth: got %h want %h", rdata, 32'h55); end
    load(8'h04);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rx_load_empty: got %h want 0", rdata); end
  endtask

  task automatic test_rx_simul();
    logic [7:0] a, b, c;
    do_reset();
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    rx_data_in_valid = 1'b1;
    rx_data_in = a; tick();
    rx_data_in = b; tick();
    rx_data_in = c;
    load(8'h04);
    rx_data_in_valid = 1'b0;
    n_checks++; if (rdata !== {24'd0, a}) begin n_fail++; $display("FAIL simul_pop: got %h want %h", rdata, a); end
    load(8'h04);
    n_checks++; if (rdata !== {24'd0, b}) begin n_fail++; $display("FAIL simul_b: got %h want %h", rdata, b); end
    load(8'h04);
    n_checks++; if (rdata !== {24'd0, c}) begin n_fail++; $display("FAIL simul_c: got %h want %h", rdata, c); end
    load(8'h00);
    n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL simul_empty: got %h want %h", rdata, 32'h1); end
  endtask

  task automatic test_tx();
    do_reset();
    store(8'h08, 32'h41);
    n_checks++; if (tx_data_out_valid !== 1'b1 || tx_data_out !== 8'h41) begin n_fail++; $display("FAIL tx_load: got %b/%h want 1/41", tx_data_out_valid, tx_data_out); end
    load(8'h00);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL tx_busy_status: got %h want 0", rdata); end
    store(8'h08, 32'h42);
    n_checks++; if (tx_data_out !== 8'h41) begin n_fail++; $display("FAIL tx_drop: got %h want 41", tx_data_out); end
    load(8'h00);
    n_checks++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL tx_ovf_status: got %h want %h", rdata, 32'h4); end
    store(8'h00, 32'h4);
    load(8'h00);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL tx_ovf_clear: got %h want 0", rdata); end
    tx_data_out_ready = 1'b1;
    store(8'h08, 32'h43);
    n_checks++; if (tx_data_out_valid !== 1'b1 || tx_data_out !== 8'h43) begin n_fail++; $display("FAIL tx_hs_reload: got %b/%h want 1/43", tx_data_out_valid, tx_data_out); end
    tick();
    n_checks++; if (tx_data_out_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain: got %b want 0", tx_data_out_valid); end
    tx_data_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rx_data_in_valid = 1'b1;
    rx_data_in = 8'hA1; tick();
    rx_data_in = 8'hB2; tick();
    rx_data_in_valid = 1'b0;
    store(8'h08, 32'h5A);
    n_checks++; if (tx_data_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", tx_data_out_valid); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx_data_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: got %b want 0", tx_data_out_valid); end
    #1 rst = 1'b1;
    m_reset();
    load(8'h00);
    n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL mid_status: got %h want %h", rdata, 32'h1); end
    load(8'h04);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rx_empty: got %h want 0", rdata); end
  endtask

  task automatic test_unmapped();
    load(8'h00);
    load(8'h0C);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", rdata); end
    store(8'h1C, $urandom);
    n_checks++; if (tx_data_out_valid !== 1'b0) begin n_fail++; $display("FAIL unmapped_write_tx: got %b want 0", tx_data_out_valid); end
    load(8'h00);
    n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL unmapped_write_status: got %h want %h", rdata, 32'h1); end
    n_checks++; if (rdata !== m_rd) begin n_fail++; $display("FAIL unmapped_model: got %h want %h", rdata, m_rd); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [8];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid         = ($urandom_range(0, 3) != 0);
      req_we            = $urandom_range(0, 1) == 1;
      req_addr          = addrs[$urandom_range(0, 7)];
      req_wdata         = $urandom;
      instr_retired     = $urandom_range(0, 1) == 1;
      rx_data_in        = 8'($urandom);
      rx_data_in_valid  = $urandom_range(0, 1) == 1;
      tx_data_out_ready = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++; if (rdata !== m_rd) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h want %h", i, rdata, m_rd); end
      n_checks++; if (tx_data_out_valid !== m_tx_v || tx_data_out !== m_tx_d) begin n_fail++; $display("FAIL rnd_tx@%0d: got %b/%h want %b/%h", i, tx_data_out_valid, tx_data_out, m_tx_v, m_tx_d); end
      n_checks++; if (rx_data_in_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_rx_ready@%0d: got %b want %b", i, rx_data_in_ready, (m_q.size() < DEPTH)); end
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    m_reset();
    test_reset();
    test_counters();
    test_rx_fill();
    test_rx_simul();
    test_tx();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
